// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: emits the sixteen 48-bit round subkeys one per
// cycle over a valid/ready stream, forward for encrypt or reversed for decrypt.
module des_key_schedule #(
  parameter int PARITY_CHECK = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        decrypt_i,
  input  logic [63:0] key_i,
  input  logic        ready_i,
  output logic        subkey_valid_o,
  output logic [47:0] subkey_o,
  output logic [3:0]  round_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        key_err_o
);

  // state | meaning
  // IDLE  | waiting for start_i; done_o / key_err_o reported here
  // RUN   | presenting subkey index round_o, advancing on ready_i
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Tables use DES numbering: entry value 1 is the MSB of the source vector.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  src;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      src = 6'(64 - PC1_TAB[i]);
      r[6'(55 - i)] = k[src];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  src;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      src = 6'(56 - PC2_TAB[i]);
      r[6'(47 - i)] = cd[src];
    end
    return r;
  endfunction

  // Shift schedule: rounds 1, 2, 9 and 16 rotate by one, all others by two.
  function automatic logic shift_two(input logic [4:0] n);
    return !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  logic [0:0]  state_q;
  logic [27:0] c_q, d_q;
  logic [3:0]  cnt_q;
  logic        dir_q;
  logic        done_q;
  logic        key_err_q;

  logic [55:0] cd0;
  logic [27:0] c0, d0;
  logic        parity_bad;
  logic [4:0]  sched_idx;
  logic        step_two;
  logic [27:0] c_next, d_next;

  always_comb begin
    cd0 = pc1(key_i);
    c0  = cd0[55:28];
    d0  = cd0[27:0];
    parity_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      parity_bad = parity_bad | ~(^key_i[b*8 +: 8]);
    end
  end

  // Encrypt moves from K(j+1) to K(j+2); decrypt undoes the shift that produced K(16-j).
  always_comb begin
    sched_idx = dir_q ? (5'd16 - {1'b0, cnt_q}) : ({1'b0, cnt_q} + 5'd2);
    step_two  = shift_two(sched_idx);
    c_next    = dir_q ? rotr28(c_q, step_two) : rotl28(c_q, step_two);
    d_next    = dir_q ? rotr28(d_q, step_two) : rotl28(d_q, step_two);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      c_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if ((PARITY_CHECK != 0) && parity_bad) begin
              key_err_q <= 1'b1;
            end else begin
              // C16/D16 equal C0/D0, so decrypt starts from the unshifted halves.
              c_q       <= decrypt_i ? c0 : rotl28(c0, 1'b0);
              d_q       <= decrypt_i ? d0 : rotl28(d0, 1'b0);
              cnt_q     <= '0;
              dir_q     <= decrypt_i;
              key_err_q <= 1'b0;
              state_q   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (ready_i) begin
            if (cnt_q == 4'd15) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
              c_q   <= c_next;
              d_q   <= d_next;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign subkey_valid_o = (state_q == ST_RUN);
  assign busy_o         = (state_q == ST_RUN);
  assign subkey_o       = pc2({c_q, d_q});
  assign round_o        = cnt_q;
  assign done_o         = done_q;
  assign key_err_o      = key_err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: directed steps with a scoreboard of expected
// subkeys popped on every valid/ready handshake.
module tb_des_key_schedule;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        decrypt_i = 1'b0;
  logic [63:0] key_i = '0;
  logic        ready_i = 1'b1;
  logic        subkey_valid_o;
  logic [47:0] subkey_o;
  logic [3:0]  round_o;
  logic        busy_o;
  logic        done_o;
  logic        key_err_o;

  des_key_schedule #(.PARITY_CHECK(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .decrypt_i(decrypt_i),
    .key_i(key_i), .ready_i(ready_i), .subkey_valid_o(subkey_valid_o),
    .subkey_o(subkey_o), .round_o(round_o), .busy_o(busy_o),
    .done_o(done_o), .key_err_o(key_err_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;

  // Published K1..K16 for KEY_A.
  localparam logic [47:0] KA [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef struct packed {
    logic [3:0]  rnd;
    logic [47:0] key;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Kn computed directly from C0/D0 by the cumulative shift count.
  function automatic logic [47:0] model_key(input logic [63:0] k, input int n);
    logic [55:0] cd;
    logic [55:0] cc, dd;
    logic [27:0] c, d;
    logic [47:0] r;
    int t;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - M_PC1[i])];
    t = 0;
    for (int s = 1; s <= n; s++) t += (s == 1 || s == 2 || s == 9 || s == 16) ? 1 : 2;
    t = t % 28;
    cc = {cd[55:28], cd[55:28]} << t;
    dd = {cd[27:0], cd[27:0]} << t;
    c = cc[55:28];
    d = dd[55:28];
    cd = {c, d};
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - M_PC2[i])];
    return r;
  endfunction

  task automatic push_a(input logic dec, input int count);
    exp_t e;
    for (int j = 0; j < count; j++) begin
      e.rnd = 4'(j);
      e.key = dec ? KA[15 - j] : KA[j];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_model(input logic [63:0] k, input logic dec);
    exp_t e;
    for (int j = 0; j < 16; j++) begin
      e.rnd = 4'(j);
      e.key = model_key(k, dec ? (16 - j) : (j + 1));
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (subkey_valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {60'd0, round_o}, 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_round", {60'd0, round_o}, {60'd0, e.rnd});
        check("sb_subkey", {16'd0, subkey_o}, {16'd0, e.key});
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [63:0] k, input logic dec);
    key_i = k;
    decrypt_i = dec;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    key_i = {$urandom, $urandom};
    decrypt_i = 1'($urandom);
  endtask

  task automatic wait_done(output int busy_n);
    busy_n = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_o) break;
      if (busy_o) busy_n++;
      cyc();
    end
    check("done_seen", {63'd0, done_o}, 64'd1);
  endtask

  initial begin
    int bc;
    int dexp;
    dexp = 0;

    cyc();
    cyc();
    check("reset_outs", {8'd0, subkey_valid_o, subkey_o, round_o, busy_o, done_o, key_err_o}, 64'd0);
    rst_i = 1'b0;
    cyc();

    // Encrypt with ready high: first subkey the cycle after start, done 16 cycles later.
    push_a(1'b0, 16);
    do_start(KEY_A, 1'b0);
    check("enc_first_valid", {63'd0, subkey_valid_o}, 64'd1);
    wait_done(bc);
    dexp++;
    check("enc_busy_cycles", 64'(bc), 64'd16);
    check("enc_done_busy", {63'd0, busy_o}, 64'd0);
    cyc();
    check("enc_done_pulse", {63'd0, done_o}, 64'd0);
    check("enc_drain", 64'(exp_q.size()), 64'd0);

    // Decrypt: reversed sequence.
    push_a(1'b1, 16);
    do_start(KEY_A, 1'b1);
    wait_done(bc);
    dexp++;
    check("dec_busy_cycles", 64'(bc), 64'd16);
    cyc();
    check("dec_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure: ready low for three cycles at index 5.
    push_a(1'b0, 16);
    do_start(KEY_A, 1'b0);
    for (int j = 0; j < 5; j++) cyc();
    ready_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("bp_round", {60'd0, round_o}, 64'd5);
      check("bp_subkey", {16'd0, subkey_o}, {16'd0, KA[5]});
      cyc();
    end
    ready_i = 1'b1;
    check("bp_round_resume", {60'd0, round_o}, 64'd5);
    wait_done(bc);
    dexp++;
    check("bp_total_cycles", 64'(bc + 8), 64'd19);
    cyc();
    check("bp_drain", 64'(exp_q.size()), 64'd0);

    // Parity failure rejects the start; a good key afterwards runs normally.
    do_start(KEY_BAD, 1'b0);
    check("par_err_set", {63'd0, key_err_o}, 64'd1);
    check("par_idle", {62'd0, busy_o, subkey_valid_o}, 64'd0);
    cyc();
    cyc();
    check("par_still_idle", {62'd0, busy_o, key_err_o}, 64'd1);
    check("par_no_done", 64'(done_cnt), 64'(dexp));
    push_a(1'b0, 16);
    do_start(KEY_A, 1'b0);
    check("par_err_clear", {63'd0, key_err_o}, 64'd0);
    wait_done(bc);
    dexp++;
    check("par_run_cycles", 64'(bc), 64'd16);
    cyc();

    // Asynchronous reset in the middle of index 8.
    push_a(1'b0, 8);
    do_start(KEY_A, 1'b0);
    for (int j = 0; j < 8; j++) cyc();
    check("rst_pre_round", {60'd0, round_o}, 64'd8);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_async_outs", {8'd0, subkey_valid_o, subkey_o, round_o, busy_o, done_o, key_err_o}, 64'd0);
    cyc();
    cyc();
    rst_i = 1'b0;
    cyc();
    check("rst_no_done", 64'(done_cnt), 64'(dexp));
    check("rst_drain", 64'(exp_q.size()), 64'd0);
    push_a(1'b1, 16);
    do_start(KEY_A, 1'b1);
    check("rst_dec_first", {16'd0, subkey_o}, {16'd0, KA[15]});
    wait_done(bc);
    dexp++;

    // Back-to-back: new start in the done cycle, then a stray start mid-run.
    push_model(KEY_B, 1'b0);
    do_start(KEY_B, 1'b0);
    wait_done(bc);
    dexp++;
    push_a(1'b1, 16);
    do_start(KEY_A, 1'b1);
    check("b2b_accepted", {63'd0, busy_o}, 64'd1);
    cyc();
    cyc();
    key_i = KEY_B;
    decrypt_i = 1'b0;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    wait_done(bc);
    dexp++;
    check("b2b_cycles", 64'(bc + 3), 64'd16);
    cyc();
    check("b2b_drain", 64'(exp_q.size()), 64'd0);
    check("done_total", 64'(done_cnt), 64'(dexp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
